// File: rtl/uart_reg_bridge_pkg.sv
// Shared opcodes, response characters and FSM encoding for the UART register bridge.
package uart_reg_bridge_pkg;

   localparam logic [7:0] OP_WR  = 8'h57;
   localparam logic [7:0] OP_RD  = 8'h52;
   localparam logic [7:0] CH_ACK = 8'h06;
   localparam logic [7:0] CH_NAK = 8'h15;

   localparam int RESP_BYTES = 5;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      REQ,
      RESP
   } state_e;

endpackage

// File: rtl/uart_reg_bridge_txser.sv
// Response serialiser: up to 5 queued bytes out MSB first; UART_REG_BRIDGE_CSUM_EN appends their XOR.
// First byte offered the cycle after load; a low tx_ready holds the current byte and tx_char stable.
module uart_reg_bridge_txser
   import uart_reg_bridge_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ld,
   input  logic [2:0]              ld_n,
   input  logic [8*RESP_BYTES-1:0] ld_dat,
   input  logic                    tx_ready,
   output logic                    tx_wr,
   output logic [8:0]              tx_char,
   output logic                    active
);

   localparam int SH_W = 8 * RESP_BYTES;

   logic [SH_W-1:0] sh_q, sh_d;
   logic [2:0]      cnt_q, cnt_d;
`ifdef UART_REG_BRIDGE_CSUM_EN
   logic [7:0]      sum_q, sum_d;
   logic            pend_q, pend_d;
`endif

   assign active  = (cnt_q != 3'd0);
   assign tx_wr   = active && tx_ready;
   assign tx_char = {1'b0, sh_q[SH_W-1 -: 8]};

   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
`ifdef UART_REG_BRIDGE_CSUM_EN
      sum_d  = sum_q;
      pend_d = pend_q;
`endif
      if (ld) begin
         sh_d  = ld_dat;
         cnt_d = ld_n;
`ifdef UART_REG_BRIDGE_CSUM_EN
         sum_d  = 8'h00;
         pend_d = 1'b1;
`endif
      end else if (tx_wr) begin
`ifdef UART_REG_BRIDGE_CSUM_EN
         sum_d = sum_q ^ sh_q[SH_W-1 -: 8];
         // Last payload byte leaves: slot the running XOR in as one extra byte.
         if (pend_q && cnt_q == 3'd1) begin
            sh_d   = {sum_q ^ sh_q[SH_W-1 -: 8], {(SH_W-8){1'b0}}};
            pend_d = 1'b0;
         end else begin
            sh_d  = {sh_q[SH_W-9:0], 8'h00};
            cnt_d = cnt_q - 3'd1;
         end
`else
         sh_d  = {sh_q[SH_W-9:0], 8'h00};
         cnt_d = cnt_q - 3'd1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= 3'd0;
`ifdef UART_REG_BRIDGE_CSUM_EN
         sum_q  <= 8'h00;
         pend_q <= 1'b0;
`endif
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
`ifdef UART_REG_BRIDGE_CSUM_EN
         sum_q  <= sum_d;
         pend_q <= pend_d;
`endif
      end
   end

endmodule

// File: rtl/uart_reg_bridge.sv
// Serial command decoder driving a single-master register bus; UART_REG_BRIDGE_CSUM_EN adds XOR checksums.
// 2 cycles/byte min, reg_req the cycle after the last byte, reply the cycle after ack; tx stalls on tx_ready.
module uart_reg_bridge
   import uart_reg_bridge_pkg::*;
#(
   parameter int          ADDR_W = 16,
   parameter int          DATA_W = 32,
   parameter logic [15:0] TMO    = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [8:0]        rx_char,
   input  logic              rx_valid,
   output logic              rx_rd,
   input  logic              tx_ready,
   output logic              tx_wr,
   output logic [8:0]        tx_char,
   output logic              reg_req,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic              reg_ack,
   output logic [7:0]        err_cnt,
   output logic              busy
);

   state_e              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                rd_q, rd_d;
   logic                samp_q, samp_d;
   logic [15:0]         tmo_q, tmo_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                req_q, req_d;
   logic [7:0]          err_q, err_d;
`ifdef UART_REG_BRIDGE_CSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   logic                err_inc;
   logic                ld;
   logic [2:0]          ld_n;
   logic [8*RESP_BYTES-1:0] ld_dat;
   logic                tx_active;
   logic                tmo_hit;
   logic [7:0]          rx_byte;
   logic                rx_brk;

   assign tmo_hit = (tmo_q == TMO - 16'd1);
   assign rx_byte = rx_char[7:0];
   assign rx_brk  = rx_char[8];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      req_d   = req_q;
      samp_d  = rd_q;
      err_inc = 1'b0;
      ld      = 1'b0;
      ld_n    = 3'd1;
      ld_dat  = {CH_NAK, {DATA_W{1'b0}}};
`ifdef UART_REG_BRIDGE_CSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (samp_q && !rx_brk) begin
               if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                  wr_d    = (rx_byte == OP_WR);
                  cnt_d   = 3'd0;
                  tmo_d   = 16'd0;
                  state_d = ADDR;
`ifdef UART_REG_BRIDGE_CSUM_EN
                  csum_d  = rx_byte;
`endif
               end else begin
                  ld      = 1'b1;
                  err_inc = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ADDR: begin
            if (samp_q) begin
               tmo_d = 16'd0;
               if (rx_brk) begin
                  state_d = IDLE;
               end else begin
                  addr_d = {addr_q[ADDR_W-9:0], rx_byte};
                  cnt_d  = cnt_q + 3'd1;
`ifdef UART_REG_BRIDGE_CSUM_EN
                  csum_d = csum_q ^ rx_byte;
`endif
                  if (cnt_q == 3'd1) begin
                     cnt_d = 3'd0;
`ifdef UART_REG_BRIDGE_CSUM_EN
                     state_d = DATA;
`else
                     if (wr_q) begin
                        state_d = DATA;
                     end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                     end
`endif
                  end
               end
            end else if (!rd_q) begin
               if (tmo_hit) begin
                  state_d = IDLE;
                  err_inc = 1'b1;
               end else begin
                  tmo_d = tmo_q + 16'd1;
               end
            end
         end
         DATA: begin
            if (samp_q) begin
               tmo_d = 16'd0;
               if (rx_brk) begin
                  state_d = IDLE;
`ifdef UART_REG_BRIDGE_CSUM_EN
               end else if (cnt_q == (wr_q ? 3'd4 : 3'd0)) begin
                  // Reads carry only the checksum byte here; writes carry 4 data bytes first.
                  if (rx_byte == csum_q) begin
                     state_d = REQ;
                     req_d   = 1'b1;
                  end else begin
                     ld      = 1'b1;
                     err_inc = 1'b1;
                     state_d = RESP;
                  end
               end else begin
                  wdata_d = {wdata_q[DATA_W-9:0], rx_byte};
                  csum_d  = csum_q ^ rx_byte;
                  cnt_d   = cnt_q + 3'd1;
               end
`else
               end else begin
                  wdata_d = {wdata_q[DATA_W-9:0], rx_byte};
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd3) begin
                     state_d = REQ;
                     req_d   = 1'b1;
                  end
               end
`endif
            end else if (!rd_q) begin
               if (tmo_hit) begin
                  state_d = IDLE;
                  err_inc = 1'b1;
               end else begin
                  tmo_d = tmo_q + 16'd1;
               end
            end
         end
         REQ: begin
            if (reg_ack) begin
               req_d   = 1'b0;
               ld      = 1'b1;
               ld_n    = wr_q ? 3'd1 : 3'd5;
               ld_dat  = wr_q ? {CH_ACK, {DATA_W{1'b0}}} : {CH_ACK, reg_rdata};
               state_d = RESP;
            end else if (tmo_hit) begin
               req_d   = 1'b0;
               ld      = 1'b1;
               err_inc = 1'b1;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         RESP: begin
            if (!tx_active) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Timer restarts on entry to REQ; every other path keeps the value set above.
      if (state_q != REQ && state_d == REQ) begin
         tmo_d = 16'd0;
      end

      rd_d  = rx_valid && !rd_q && (state_d inside {IDLE, ADDR, DATA});
      err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         rd_q    <= 1'b0;
         samp_q  <= 1'b0;
         tmo_q   <= 16'd0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         req_q   <= 1'b0;
         err_q   <= 8'h00;
`ifdef UART_REG_BRIDGE_CSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         samp_q  <= samp_d;
         tmo_q   <= tmo_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         req_q   <= req_d;
         err_q   <= err_d;
`ifdef UART_REG_BRIDGE_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   uart_reg_bridge_txser u_txser (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .ld_n     (ld_n),
      .ld_dat   (ld_dat),
      .tx_ready (tx_ready),
      .tx_wr    (tx_wr),
      .tx_char  (tx_char),
      .active   (tx_active)
   );

   assign rx_rd     = rd_q;
   assign reg_req   = req_q;
   assign reg_wr    = wr_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign err_cnt   = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with an rx FIFO model and a tx byte scoreboard.
module tb_uart_reg_bridge;

   localparam logic [15:0] TMO = 16'd64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  rx_char = 9'h000;
   logic        rx_valid;
   logic        rx_rd;
   logic        tx_ready;
   logic        tx_wr;
   logic [8:0]  tx_char;
   logic        reg_req;
   logic        reg_wr;
   logic [15:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata = 32'h0;
   logic        reg_ack = 1'b0;
   logic [7:0]  err_cnt;
   logic        busy;

   int total = 0;
   int bad = 0;
   int exp_err = 0;
   int req_cyc = 0;

   logic [8:0] rxmem [0:1023];
   int         rx_wp = 0;
   int         rx_rp = 0;

   logic       tx_en = 1'b1;
   logic       tx_tog = 1'b0;
   logic       tog_ph = 1'b0;

   logic [7:0] exq[$];
   logic [7:0] fr[$];
   logic [7:0] rs[$];

   logic [8:0] stall_ch = 9'h000;
   bit         stall_v = 0;
   bit         resp_seen = 0;

   always #5 clk = ~clk;

   uart_reg_bridge #(.ADDR_W(16), .DATA_W(32), .TMO(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_char   (rx_char),
      .rx_valid  (rx_valid),
      .rx_rd     (rx_rd),
      .tx_ready  (tx_ready),
      .tx_wr     (tx_wr),
      .tx_char   (tx_char),
      .reg_req   (reg_req),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   assign rx_valid = (rx_wp != rx_rp);
   assign tx_ready = tx_tog ? tog_ph : tx_en;

   always @(posedge clk) begin
      tog_ph <= ~tog_ph;
      if (rx_rd) begin
         rx_char <= rxmem[rx_rp % 1024];
         rx_rp   <= rx_rp + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // tx monitor: every written byte is popped from the scoreboard; stalled bytes must not change.
   always @(negedge clk) begin
      if (reg_req) req_cyc++;
      if (tx_wr) begin
         if (stall_v) chk("tx_hold", tx_char, stall_ch);
         stall_v   = 0;
         resp_seen = 1;
         chk("tx_expected", exq.size() != 0, 1);
         if (exq.size() != 0) chk("tx_byte", tx_char, {1'b0, exq.pop_front()});
      end else if (busy && !tx_ready && resp_seen) begin
         if (stall_v) chk("tx_stall", tx_char, stall_ch);
         stall_ch = tx_char;
         stall_v  = 1;
      end
      if (!busy) begin
         stall_v   = 0;
         resp_seen = 0;
      end
   end

   task automatic push_rx(input logic [8:0] c);
      rxmem[rx_wp % 1024] = c;
      rx_wp++;
   endtask

   task automatic send_frame();
`ifdef UART_REG_BRIDGE_CSUM_EN
      logic [7:0] s;
      s = 8'h00;
      foreach (fr[i]) s ^= fr[i];
`endif
      foreach (fr[i]) push_rx({1'b0, fr[i]});
`ifdef UART_REG_BRIDGE_CSUM_EN
      push_rx({1'b0, s});
`endif
      fr.delete();
   endtask

   task automatic expect_resp();
`ifdef UART_REG_BRIDGE_CSUM_EN
      logic [7:0] s;
      s = 8'h00;
      foreach (rs[i]) s ^= rs[i];
`endif
      foreach (rs[i]) exq.push_back(rs[i]);
`ifdef UART_REG_BRIDGE_CSUM_EN
      exq.push_back(s);
`endif
      rs.delete();
   endtask

   task automatic wait_req();
      int n = 0;
      while (!reg_req && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", reg_req, 1);
   endtask

   task automatic do_ack(input logic [31:0] rd, input int dly);
      repeat (dly) @(negedge clk);
      reg_rdata = rd;
      reg_ack   = 1'b1;
      @(negedge clk);
      reg_ack   = 1'b0;
      chk("req_drop", reg_req, 0);
   endtask

   task automatic wait_idle(input string tag);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 5000) begin
         @(negedge clk);
         n++;
         if (!busy && exq.size() == 0 && rx_wp == rx_rp) quiet++;
         else quiet = 0;
      end
      chk({tag, "_drain"}, exq.size(), 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   task automatic bump_err();
      if (exp_err < 255) exp_err++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      repeat (3) @(negedge clk);
      chk("rst_rx_rd", rx_rd, 0);
      chk("rst_tx_wr", tx_wr, 0);
      chk("rst_reg_req", reg_req, 0);
      chk("rst_reg_wr", reg_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_char", tx_char, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_reg_wdata", reg_wdata, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      // Write with ack in the first request cycle
      fr = '{8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame();
      rs = '{8'h06};
      expect_resp();
      wait_req();
      chk("wr_reg_wr", reg_wr, 1);
      chk("wr_addr", reg_addr, 16'h0010);
      chk("wr_wdata", reg_wdata, 32'hDEADBEEF);
      do_ack(32'h0, 0);
      wait_idle("wr");

      // Read
      fr = '{8'h52, 8'h12, 8'h34};
      send_frame();
      rs = '{8'h06, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      expect_resp();
      wait_req();
      chk("rd_reg_wr", reg_wr, 0);
      chk("rd_addr", reg_addr, 16'h1234);
      do_ack(32'hCAFEF00D, 3);
      wait_idle("rd");

      // Unknown opcode
      c0 = req_cyc;
      push_rx(9'h041);
      rs = '{8'h15};
      expect_resp();
      bump_err();
      wait_idle("badop");
      chk("badop_err", err_cnt, exp_err);
      chk("badop_noreq", req_cyc, c0);

      // Inter-byte timeout
      push_rx(9'h057);
      push_rx(9'h000);
      repeat (TMO - 8) @(negedge clk);
      chk("tmo_still_busy", busy, 1);
      repeat (16) @(negedge clk);
      chk("tmo_idle", busy, 0);
      bump_err();
      chk("tmo_err", err_cnt, exp_err);

      // Break mid-frame
      push_rx(9'h052);
      push_rx(9'h012);
      push_rx(9'h100);
      wait_idle("brk");
      chk("brk_err", err_cnt, exp_err);

      // Read with tx_ready toggling every cycle
      tx_tog = 1'b1;
      fr = '{8'h52, 8'hAB, 8'hCD};
      send_frame();
      rs = '{8'h06, 8'h01, 8'h23, 8'h45, 8'h67};
      expect_resp();
      wait_req();
      chk("tog_addr", reg_addr, 16'hABCD);
      do_ack(32'h01234567, 1);
      wait_idle("tog");
      tx_tog = 1'b0;

      // Register access timeout
      fr = '{8'h52, 8'h00, 8'h05};
      send_frame();
      rs = '{8'h15};
      expect_resp();
      bump_err();
      wait_req();
      repeat (TMO - 8) @(negedge clk);
      chk("reqtmo_held", reg_req, 1);
      wait_idle("reqtmo");
      chk("reqtmo_req_low", reg_req, 0);
      chk("reqtmo_err", err_cnt, exp_err);

      // Stray ack while idle
      reg_ack = 1'b1;
      @(negedge clk);
      reg_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_ack_busy", busy, 0);
      chk("stray_ack_err", err_cnt, exp_err);

`ifdef UART_REG_BRIDGE_CSUM_EN
      push_rx(9'h052);
      push_rx(9'h000);
      push_rx(9'h001);
      push_rx(9'h053);
      rs = '{8'h06, 8'h13, 8'h57, 8'h9B, 8'hDF};
      expect_resp();
      wait_req();
      chk("cs_addr", reg_addr, 16'h0001);
      do_ack(32'h13579BDF, 0);
      wait_idle("cs_ok");

      c0 = req_cyc;
      push_rx(9'h052);
      push_rx(9'h000);
      push_rx(9'h001);
      push_rx(9'h054);
      rs = '{8'h15};
      expect_resp();
      bump_err();
      wait_idle("cs_bad");
      chk("cs_bad_noreq", req_cyc, c0);
      chk("cs_bad_err", err_cnt, exp_err);
`endif

      // Reset in the middle of an access
      fr = '{8'h52, 8'h00, 8'h07};
      send_frame();
      wait_req();
      rst = 1'b1;
      #1;
      chk("midrst_req", reg_req, 0);
      chk("midrst_err", err_cnt, 0);
      exp_err = 0;
      @(negedge clk);
      rst = 1'b0;
      wait_idle("midrst");

      // Error counter saturation
      for (int i = 0; i < 260; i++) begin
         push_rx(9'h041);
         rs = '{8'h15};
         expect_resp();
         bump_err();
      end
      wait_idle("sat");
      chk("sat_err", err_cnt, 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
